meter_session_ctrl: RTL
=======================

Name: meter_session_ctrl

Overview:
Session sequencer for the parking-meter cost datapath.
- Starts a parking session and freezes the location/hour switch settings for its duration.
- Counts elapsed seconds on a 1 Hz tick and presents the count to the combinational cost converter.
- On stop, waits for the converter output to settle, latches the cost, and holds it with a valid/ack handshake until the payment/display logic accepts it.

Parameters:
SEC_W, 12, width of the elapsed-second counter (matches the cost converter's sec_count input).
MAX_SEC, 4095, saturation value of the second counter; reaching it forces the session to stop.
SETTLE, 2, clock cycles spent in CALC before cost_in is sampled (min 1).
TIMEOUT_SEC, 30, ticks in HOLD before an unpaid abort (used only with PAY_TIMEOUT_EN).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick_1hz  in  1  one-clk-wide pulse, once per second
btn_start  in  1  debounced single-cycle start pulse
btn_stop  in  1  debounced single-cycle stop pulse
sw  in  8  live switches: [7:5] location, [4:0] hour
rate_sw  out  8  switches latched at session start; drives the cost converter
sec_count  out  SEC_W  elapsed seconds; drives the cost converter
cost_in  in  14  cost in cents returned by the cost converter
cost_out  out  14  latched session cost
cost_valid  out  1  cost_out valid, held until ack
cost_ack  in  1  consumer accepts cost_out
busy  out  1  high in RUN, CALC, HOLD
overflow  out  1  session ended by saturation; cleared at next start
unpaid  out  1  one-cycle pulse on payment timeout (0 when feature is off)

Behaviour:
- Reset (async, immediate): state=IDLE. rate_sw=0, sec_count=0, cost_out=0, cost_valid=0, busy=0, overflow=0, unpaid=0. Internal counters are cleared. Reset mid-session discards the session with no cost output.
- All outputs are registered; state changes take effect on the clk edge after the triggering input.
- IDLE:
  - btn_start: rate_sw<=sw, sec_count<=0, overflow<=0, go to RUN.
  - btn_stop and cost_ack are ignored.
- RUN:
  - tick_1hz: sec_count<=sec_count+1, saturating at MAX_SEC.
  - If the increment reaches MAX_SEC: overflow<=1, go to CALC.
  - btn_stop: go to CALC.
  - tick and stop in the same cycle: the tick is counted, then go to CALC.
  - btn_start is ignored. sw changes are ignored (rate_sw frozen).
- CALC:
  - sec_count and rate_sw are held.
  - An internal counter runs SETTLE cycles. In the last cycle, cost_out<=cost_in and cost_valid<=1, go to HOLD.
  - Latency from stop pulse to cost_valid high is SETTLE+1 cycles.
  - Ticks, start and stop are ignored.
- HOLD:
  - cost_valid=1; cost_out and sec_count are stable.
  - cost_ack high at an edge: cost_valid<=0, sec_count<=0, go to IDLE. btn_start in that same cycle is ignored; a new start must arrive in IDLE.
  - cost_ack while cost_valid=0 has no effect.
- busy=1 exactly in RUN/CALC/HOLD.
- 2-bit state encoding: IDLE=0, RUN=1, CALC=2, HOLD=3. The unreachable encoding is not used since all four are valid.
- Arithmetic: unsigned. sec_count never wraps. cost_in is captured verbatim with no scaling.

Optional Feature:
PAY_TIMEOUT_EN
- Defined:
  - HOLD counts tick_1hz pulses from entry.
  - On the TIMEOUT_SEC-th tick with no ack: unpaid=1 for one cycle, cost_valid<=0, sec_count<=0, go to IDLE. cost_out retains its value.
  - Ack and the timeout tick in the same cycle: the ack wins and unpaid stays 0.
- Undefined: HOLD waits indefinitely; unpaid is tied to 0 and no timeout counter is built.

Test Plan:
- Basic session:
  - Stimulus: sw=8'h09, pulse start, 125 ticks, pulse stop, bench model drives cost_in=14'd5.
  - Required: rate_sw=8'h09, sec_count=125, cost_valid rises SETTLE+1 (=3) cycles after stop with cost_out=5. Ack -> IDLE, sec_count=0, busy=0.
- Frozen rate:
  - Stimulus: start with sw=8'h2D, change sw to 8'hE0 mid-RUN.
  - Required: rate_sw stays 8'h2D through HOLD.
- Simultaneous tick and stop:
  - Stimulus: after 10 ticks, assert tick and stop in the same cycle.
  - Required: sec_count=11, state CALC.
- Saturation:
  - Stimulus: force 4095 ticks with no stop.
  - Required: sec_count=4095, overflow=1, auto CALC -> HOLD. Further ticks do not change sec_count. Next start clears overflow.
- Reset mid-RUN:
  - Stimulus: start, 7 ticks, assert rst.
  - Required: all outputs 0 immediately (asynchronously). A stray cost_ack after reset leaves IDLE unchanged.
- Timeout (PAY_TIMEOUT_EN defined):
  - Stimulus: reach HOLD, give 30 ticks with no ack.
  - Required: unpaid high for one cycle, cost_valid=0, IDLE.
  - Repeat with ack on the 30th tick: unpaid stays 0.

Source files
------------

// File: rtl/meter_session_ctrl_if.sv
// Link between the session sequencer, the cost converter and the payment/display consumer.
interface meter_session_ctrl_if #(
  parameter int unsigned SEC_W = 12
);
  logic [7:0]       rate_sw;
  logic [SEC_W-1:0] sec_count;
  logic [13:0]      cost_in;
  logic [13:0]      cost_out;
  logic             cost_valid;
  logic             cost_ack;

  modport master (
    output rate_sw, sec_count, cost_out, cost_valid,
    input  cost_in, cost_ack
  );

  modport slave (
    input  rate_sw, sec_count, cost_out, cost_valid,
    output cost_in, cost_ack
  );
endinterface

// File: rtl/meter_session_ctrl.sv
// Parking-meter session sequencer: IDLE -> RUN -> CALC -> HOLD -> IDLE.
// Optional payment timeout in HOLD is enabled by defining PAY_TIMEOUT_EN.
module meter_session_ctrl #(
  parameter int unsigned SEC_W       = 12,
  parameter int unsigned MAX_SEC     = 4095,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned TIMEOUT_SEC = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_1hz,
  input  logic                 btn_start,
  input  logic                 btn_stop,
  input  logic [7:0]           sw,
  meter_session_ctrl_if.master bus,
  output logic                 busy,
  output logic                 overflow,
  output logic                 unpaid
);

  localparam int unsigned CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CALC = 2'd2,
    HOLD = 2'd3
  } state_t;

  if (SETTLE < 1) begin : g_bad_settle
    $error("SETTLE must be at least 1");
  end
  if (TIMEOUT_SEC < 1) begin : g_bad_timeout
    $error("TIMEOUT_SEC must be at least 1");
  end

  state_t           state, state_n;
  logic [7:0]       rate_r, rate_n;
  logic [SEC_W-1:0] sec_r, sec_n;
  logic [13:0]      cost_r, cost_n;
  logic             valid_r, valid_n;
  logic             ovf_r, ovf_n;
  logic             busy_r, busy_n;
  logic [CW-1:0]    settle_r, settle_n;
`ifdef PAY_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_SEC + 1);
  logic [TW-1:0]    to_r, to_n;
  logic             unpaid_r, unpaid_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rate_r   <= '0;
      sec_r    <= '0;
      cost_r   <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      settle_r <= '0;
`ifdef PAY_TIMEOUT_EN
      to_r     <= '0;
      unpaid_r <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      rate_r   <= rate_n;
      sec_r    <= sec_n;
      cost_r   <= cost_n;
      valid_r  <= valid_n;
      ovf_r    <= ovf_n;
      busy_r   <= busy_n;
      settle_r <= settle_n;
`ifdef PAY_TIMEOUT_EN
      to_r     <= to_n;
      unpaid_r <= unpaid_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    rate_n   = rate_r;
    sec_n    = sec_r;
    cost_n   = cost_r;
    valid_n  = valid_r;
    ovf_n    = ovf_r;
    settle_n = settle_r;
`ifdef PAY_TIMEOUT_EN
    to_n     = to_r;
    unpaid_n = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (btn_start) begin
          rate_n  = sw;
          sec_n   = '0;
          ovf_n   = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
        settle_n = '0;
        // A tick coinciding with stop is still counted before leaving RUN.
        if (tick_1hz && (sec_r != SEC_W'(MAX_SEC))) begin
          sec_n = sec_r + SEC_W'(1);
          if (sec_n == SEC_W'(MAX_SEC)) begin
            ovf_n   = 1'b1;
            state_n = CALC;
          end
        end
        if (btn_stop) state_n = CALC;
      end
      CALC: begin
        if (settle_r == CW'(SETTLE - 1)) begin
          cost_n  = bus.cost_in;
          valid_n = 1'b1;
          state_n = HOLD;
`ifdef PAY_TIMEOUT_EN
          to_n    = '0;
`endif
        end else begin
          settle_n = settle_r + CW'(1);
        end
      end
      HOLD: begin
        if (bus.cost_ack) begin
          valid_n = 1'b0;
          sec_n   = '0;
          state_n = IDLE;
        end
`ifdef PAY_TIMEOUT_EN
        else if (tick_1hz) begin
          if (to_r == TW'(TIMEOUT_SEC - 1)) begin
            unpaid_n = 1'b1;
            valid_n  = 1'b0;
            sec_n    = '0;
            state_n  = IDLE;
          end else begin
            to_n = to_r + TW'(1);
          end
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  assign bus.rate_sw    = rate_r;
  assign bus.sec_count  = sec_r;
  assign bus.cost_out   = cost_r;
  assign bus.cost_valid = valid_r;
  assign busy           = busy_r;
  assign overflow       = ovf_r;
`ifdef PAY_TIMEOUT_EN
  assign unpaid         = unpaid_r;
`else
  assign unpaid         = 1'b0;
`endif

endmodule
